// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the MIPS D-stage hazard decode and the hazard scoreboard:
// forward-select encoding and the T_use / T_new code points.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;
  localparam int TW     = 2;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_E    = 2'b01,
    FWD_M    = 2'b10,
    FWD_W    = 2'b11
  } fwd_sel_t;

  localparam logic [TW-1:0] TUSE_NONE = 2'b11;
  localparam logic [TW-1:0] TNEW_NONE = 2'd0;
  localparam logic [TW-1:0] TNEW_JAL  = 2'd1;
  localparam logic [TW-1:0] TNEW_ALU  = 2'd2;
  localparam logic [TW-1:0] TNEW_LW   = 2'd3;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward select for one consumer register address against the E, M and W
// producers, newest first. Unused producer slots are tied to address 0.
module hazard_fwd_sel
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = hazard_scoreboard_pkg::REG_AW,
  parameter int TW     = hazard_scoreboard_pkg::TW
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [REG_AW-1:0] e_a3,
  input  logic [TW-1:0]     e_tnew,
  input  logic [REG_AW-1:0] m_a3,
  input  logic [TW-1:0]     m_tnew,
  input  logic [REG_AW-1:0] w_a3,
  input  logic [TW-1:0]     w_tnew,
  output logic [1:0]        sel
);

  // The newest matching producer decides; if its value is not ready yet,
  // older copies of the register are stale and must not be forwarded.
  // NOTE: sel gets a default before the if-chain, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel = FWD_NONE;
    if (addr != '0) begin
      if (addr == e_a3)      sel = (e_tnew == '0) ? FWD_E : FWD_NONE;
      else if (addr == m_a3) sel = (m_tnew == '0) ? FWD_M : FWD_NONE;
      else if (addr == w_a3) sel = (w_tnew == '0) ? FWD_W : FWD_NONE;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight producers through E/M/W and derives the D-stage stall and
// the forward selects for the D, E and M consumers.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = hazard_scoreboard_pkg::REG_AW,
  parameter int TW     = hazard_scoreboard_pkg::TW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [REG_AW-1:0] D_A3,
  input  logic [TW-1:0]     T_use_rs,
  input  logic [TW-1:0]     T_use_rt,
  input  logic [TW-1:0]     D_T_new,
  output logic              stall,
  output logic [1:0]        fwd_D_rs,
  output logic [1:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt,
  output logic [1:0]        fwd_M_rt
);

  localparam logic [REG_AW-1:0] NO_REG  = '0;
  localparam logic [TW-1:0]     TNEW_Z  = '0;

  logic [REG_AW-1:0] e_rs, e_rt, e_a3, m_rt, m_a3, w_a3;
  logic [TW-1:0]     e_tnew, m_tnew, w_tnew;

  function automatic logic [TW-1:0] dec(input logic [TW-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  // NOTE: all stage state uses non-blocking assignments so every stage samples the pre-edge values of the stage before it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_rs   <= '0;
      e_rt   <= '0;
      e_a3   <= '0;
      e_tnew <= '0;
      m_rt   <= '0;
      m_a3   <= '0;
      m_tnew <= '0;
      w_a3   <= '0;
      w_tnew <= '0;
    end else begin
      m_rt   <= e_rt;
      m_a3   <= e_a3;
      m_tnew <= dec(e_tnew);
      w_a3   <= m_a3;
      w_tnew <= dec(m_tnew);
      if (stall) begin
        e_rs   <= '0;
        e_rt   <= '0;
        e_a3   <= '0;
        e_tnew <= '0;
      end else begin
        e_rs   <= D_rs;
        e_rt   <= D_rt;
        e_a3   <= D_A3;
        e_tnew <= dec(D_T_new);
      end
    end
  end

  // A D operand stalls when a producer in E or M will not have its result
  // by the time the operand is consumed; $0 never matches.
  logic stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m;

  always_comb begin
    stall_rs_e = (D_rs != '0) && (D_rs == e_a3) && (T_use_rs < e_tnew);
    stall_rs_m = (D_rs != '0) && (D_rs == m_a3) && (T_use_rs < m_tnew);
    stall_rt_e = (D_rt != '0) && (D_rt == e_a3) && (T_use_rt < e_tnew);
    stall_rt_m = (D_rt != '0) && (D_rt == m_a3) && (T_use_rt < m_tnew);
    stall      = stall_rs_e | stall_rs_m | stall_rt_e | stall_rt_m;
  end

  hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW)) u_fwd_d_rs (
    .addr(D_rs), .e_a3(e_a3), .e_tnew(e_tnew), .m_a3(m_a3), .m_tnew(m_tnew),
    .w_a3(w_a3), .w_tnew(w_tnew), .sel(fwd_D_rs)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW)) u_fwd_d_rt (
    .addr(D_rt), .e_a3(e_a3), .e_tnew(e_tnew), .m_a3(m_a3), .m_tnew(m_tnew),
    .w_a3(w_a3), .w_tnew(w_tnew), .sel(fwd_D_rt)
  );

  // The E consumer cannot forward from itself, so its E slot is tied off.
  hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW)) u_fwd_e_rs (
    .addr(e_rs), .e_a3(NO_REG), .e_tnew(TNEW_Z), .m_a3(m_a3), .m_tnew(m_tnew),
    .w_a3(w_a3), .w_tnew(w_tnew), .sel(fwd_E_rs)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW)) u_fwd_e_rt (
    .addr(e_rt), .e_a3(NO_REG), .e_tnew(TNEW_Z), .m_a3(m_a3), .m_tnew(m_tnew),
    .w_a3(w_a3), .w_tnew(w_tnew), .sel(fwd_E_rt)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .TW(TW)) u_fwd_m_rt (
    .addr(m_rt), .e_a3(NO_REG), .e_tnew(TNEW_Z), .m_a3(NO_REG), .m_tnew(TNEW_Z),
    .w_a3(w_a3), .w_tnew(w_tnew), .sel(fwd_M_rt)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a driver issues instructions and
// queues the reference model's expectations; a monitor compares each cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, D_A3;
  logic [1:0]  T_use_rs, T_use_rt, D_T_new;
  logic        stall;
  logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_A3(D_A3),
    .T_use_rs(T_use_rs), .T_use_rt(T_use_rt), .D_T_new(D_T_new),
    .stall(stall),
    .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt),
    .fwd_E_rs(fwd_E_rs), .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int stall;
    int d_rs, d_rt, e_rs, e_rt, m_rt;
  } exp_t;

  // One in-flight instruction: operands, destination and its original T_new.
  typedef struct {
    int rs, rt, a3, tnew;
  } instr_t;

  exp_t   exp_q[$];
  instr_t pipe[3];          // index 0 = in E, 1 = in M, 2 = in W
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Cycles still missing before the result of the instruction in stage s exists:
  // it entered E s+1 cycles after D, and T_new counts from D.
  function automatic int remaining(input int s);
    int r;
    r = pipe[s].tnew - (s + 1);
    return (r < 0) ? 0 : r;
  endfunction

  // Search producers from the youngest stage `first` outward; the first one
  // writing `a` decides. Encoding is stage index + 1 (E=1, M=2, W=3).
  function automatic int fwd_ref(input int a, input int first);
    for (int s = first; s < 3; s++) begin
      if (a != 0 && pipe[s].a3 == a) return (remaining(s) == 0) ? s + 1 : 0;
    end
    return 0;
  endfunction

  function automatic int stall_ref(input int rs, input int rt, input int tu_rs, input int tu_rt);
    for (int s = 0; s < 2; s++) begin
      if (rs != 0 && pipe[s].a3 == rs && tu_rs < remaining(s)) return 1;
      if (rt != 0 && pipe[s].a3 == rt && tu_rt < remaining(s)) return 1;
    end
    return 0;
  endfunction

  // Drive one cycle of D-stage inputs, queue the expectation, then advance the model.
  task automatic step(input int rs, input int rt, input int a3, input int tu_rs,
                      input int tu_rt, input int tn, input bit rst_n_val, output int st);
    exp_t   e;
    instr_t bubble;
    bubble   = '{0, 0, 0, 0};
    reset    = rst_n_val;
    D_rs     = 5'(rs);
    D_rt     = 5'(rt);
    D_A3     = 5'(a3);
    T_use_rs = 2'(tu_rs);
    T_use_rt = 2'(tu_rt);
    D_T_new  = 2'(tn);
    e.stall = stall_ref(rs, rt, tu_rs, tu_rt);
    e.d_rs  = fwd_ref(rs, 0);
    e.d_rt  = fwd_ref(rt, 0);
    e.e_rs  = fwd_ref(pipe[0].rs, 1);
    e.e_rt  = fwd_ref(pipe[0].rt, 1);
    e.m_rt  = fwd_ref(pipe[1].rt, 2);
    exp_q.push_back(e);
    st = e.stall;
    @(posedge clk);
    if (!rst_n_val) begin
      for (int s = 0; s < 3; s++) pipe[s] = bubble;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (e.stall != 0) ? bubble : '{rs, rt, a3, tn};
    end
    #1;
  endtask

  // Present one instruction in D and hold it there while it stalls.
  task automatic issue(input int rs, input int rt, input int a3, input int tu_rs,
                       input int tu_rt, input int tn);
    int st;
    int guard;
    guard = 0;
    do begin
      step(rs, rt, a3, tu_rs, tu_rt, tn, 1'b1, st);
      guard++;
    end while (st != 0 && guard < 6);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) issue(0, 0, 0, 3, 3, 0);
  endtask

  // Monitor: the DUT presents a fresh decision every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",    stall,    e.stall);
        check("fwd_D_rs", fwd_D_rs, e.d_rs);
        check("fwd_D_rt", fwd_D_rt, e.d_rt);
        check("fwd_E_rs", fwd_E_rs, e.e_rs);
        check("fwd_E_rt", fwd_E_rt, e.e_rt);
        check("fwd_M_rt", fwd_M_rt, e.m_rt);
      end
    end
  end

  initial begin
    int st;
    instr_t cur;
    bit     have;
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
    reset = 1'b0;
    D_rs = '0; D_rt = '0; D_A3 = '0;
    T_use_rs = TUSE_NONE; T_use_rt = TUSE_NONE; D_T_new = TNEW_NONE;
    repeat (2) @(posedge clk);
    #1;

    // Reset state with an idle D stage.
    drain();

    // lw $1 ; add $2,$1,$1
    issue(0, 0, 1, 1, 3, int'(TNEW_LW));
    issue(1, 1, 2, 1, 1, int'(TNEW_ALU));
    drain();

    // add $3 ; beq $3,$0
    issue(1, 2, 3, 1, 1, int'(TNEW_ALU));
    issue(3, 0, 0, 0, 0, int'(TNEW_NONE));
    drain();

    // jal ; jr $31
    issue(0, 0, 31, 3, 3, int'(TNEW_JAL));
    issue(31, 0, 0, 0, 3, int'(TNEW_NONE));
    drain();

    // ori $0 ; add $4,$0,$0
    issue(0, 0, 0, 1, 3, int'(TNEW_ALU));
    issue(0, 0, 4, 1, 1, int'(TNEW_ALU));
    drain();

    // lw $5 ; sw $5
    issue(0, 0, 5, 1, 3, int'(TNEW_LW));
    issue(0, 5, 0, 1, 2, int'(TNEW_NONE));
    drain();

    // Reset asserted during the load-use stall, then released.
    issue(0, 0, 1, 1, 3, int'(TNEW_LW));
    step(1, 1, 2, 1, 1, int'(TNEW_ALU), 1'b0, st);
    step(1, 1, 2, 1, 1, int'(TNEW_ALU), 1'b1, st);
    drain();

    // Randomized traffic on a small register set so hazards are frequent;
    // a stalled instruction stays in D, with an occasional reset.
    have = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!have) begin
        cur.rs   = $urandom_range(0, 3);
        cur.rt   = $urandom_range(0, 3);
        cur.a3   = $urandom_range(0, 3);
        cur.tnew = $urandom_range(0, 3);
      end
      step(cur.rs, cur.rt, cur.a3, $urandom_range(0, 3), $urandom_range(0, 3),
           cur.tnew, ($urandom_range(0, 63) != 0), st);
      have = (st != 0);
    end
    drain();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
